// File: rtl/shift_unit_arbiter_pkg.sv
// ============================================================================
// Module      : shift_unit_arbiter_pkg
// Description : Shared widths, limits and helpers for the shift-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_unit_arbiter_pkg;

    localparam int          SHIFT_DATA_W = 16;
    localparam int          SHIFT_AMT_W  = 4;
    localparam logic [15:0] BUSY_CNT_MAX = 16'hFFFF;

    // Saturating increment for the accepted-request counter
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == BUSY_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shifter_16bit.sv
// ============================================================================
// Module      : barrel_shifter_16bit
// Description : Combinational 16-bit logical left shifter, amount ctrl[3:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_16bit (
    input  logic [15:0] in,
    input  logic [3:0]  ctrl,
    output logic [15:0] out
);

    logic [4:0][15:0] stg;

    assign stg[0] = in;

    // Stage s shifts by 2**s when ctrl[s] is set; bits past bit 15 drop off
    for (genvar s = 0; s < 4; s++) begin : g_stage
        assign stg[s+1] = ctrl[s] ? (stg[s] << (2 ** s)) : stg[s];
    end

    assign out = stg[4];

endmodule

`default_nettype wire

// File: rtl/shift_unit_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!found && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_unit_arbiter.sv
// ============================================================================
// Module      : shift_unit_arbiter
// Description : Round-robin sharing of one barrel shifter with a registered,
//               ID-tagged valid/ready response stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [SHIFT_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [SHIFT_AMT_W*NUM_REQ-1:0]  req_amt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    output logic [SHIFT_DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]                 rsp_id,
    input  logic                            rsp_ready,
    output logic [15:0]                     busy_cnt
);

    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_idx;
    logic                    stage_free;
    logic                    accept;
    logic [SHIFT_DATA_W-1:0] sel_data;
    logic [SHIFT_AMT_W-1:0]  sel_amt;
    logic [SHIFT_DATA_W-1:0] shift_out;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [SHIFT_DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]         rsp_id_q,    rsp_id_d;
    logic [ID_W-1:0]         ptr_q,       ptr_d;
    logic [15:0]             busy_cnt_q,  busy_cnt_d;

    // The stage can load whenever it is empty or its content retires this cycle
    assign stage_free = ~rsp_valid_q | rsp_ready;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (stage_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | req_data[i*SHIFT_DATA_W +: SHIFT_DATA_W];
                sel_amt  = sel_amt  | req_amt[i*SHIFT_AMT_W +: SHIFT_AMT_W];
            end
        end
    end

    barrel_shifter_16bit u_shift (
        .in   (sel_data),
        .ctrl (sel_amt),
        .out  (shift_out)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        busy_cnt_d  = busy_cnt_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_out;
            rsp_id_d    = grant_idx;
            ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            busy_cnt_d  = sat_inc(busy_cnt_q);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            busy_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

`default_nettype wire
